// File: rtl/full_hash_pkg.sv
// Shared constants and pure functions for the full_hash byte-serial digest engine.
// FINAL-state support is selected in the top level by the LENGTH_FINAL_EN macro.
package full_hash_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE   = 2'd0;
    localparam state_t ST_ABSORB = 2'd1;
    localparam state_t ST_FINAL  = 2'd2;
    localparam state_t ST_DONE   = 2'd3;

    localparam logic [31:0] DEFAULT_IV = 32'h34550F14;
    localparam logic [31:0] K_ALL      = 32'h3AC5719E;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [7:0] sbox8(input logic [7:0] x);
        return {sbox4(x[7:4]), sbox4(x[3:0])};
    endfunction

    // Rotation amounts used here are 1..4, so a 3-bit count suffices.
    function automatic logic [7:0] rotl8(input logic [7:0] x, input logic [2:0] n);
        logic [15:0] w;
        w = {x, x} << n;
        return w[15:8];
    endfunction

    function automatic logic [7:0] k_byte(input int i);
        return K_ALL[31-8*i -: 8];
    endfunction

    function automatic logic [31:0] round(input logic [31:0] h, input logic [7:0] b);
        logic [31:0] r;
        logic [7:0]  t;
        t = sbox8(b);
        r = '0;
        for (int i = 0; i < 4; i++) begin
            r[31-8*i -: 8] = rotl8(h[31-8*((i+1)%4) -: 8] ^ t ^ k_byte(i), 3'(i+1));
        end
        return r;
    endfunction

    function automatic logic [7:0] fold(input logic [63:0] len);
        logic [7:0] f;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            f = f ^ len[8*i +: 8];
        end
        return f;
    endfunction

endpackage

// File: rtl/full_hash_round.sv
// One combinational absorb round: S-box the input byte, then mix it into each
// rotated-neighbour lane with its round constant.
module full_hash_round
    import full_hash_pkg::*;
(
    input  logic [31:0] state_in,
    input  logic [7:0]  byte_in,
    output logic [31:0] state_out
);

    logic [7:0] t;

    assign t = sbox8(byte_in);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign state_out[31-8*gi -: 8] =
                rotl8(state_in[31-8*((gi+1)%4) -: 8] ^ t ^ k_byte(gi), 3'(gi+1));
        end
    endgenerate

endmodule

// File: rtl/full_hash.sv
// Byte-serial 32-bit hash: FSM, length counter and lane registers.
// Define LENGTH_FINAL_EN to add the length-fold FINAL round before DONE.
module full_hash
    import full_hash_pkg::*;
#(
    parameter int          LEN_W = 64,
    parameter logic [31:0] IV    = DEFAULT_IV
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             M_valid,
    input  logic [LEN_W-1:0] C_in,
    input  logic [7:0]       M,
    output logic             hash_ready,
    output logic [31:0]      digest
);

`ifdef LENGTH_FINAL_EN
    localparam state_t ST_AFTER_LAST = ST_FINAL;
`else
    localparam state_t ST_AFTER_LAST = ST_DONE;
`endif

    state_t           state_q, state_d;
    logic [31:0]      h_q, h_d;
    logic [LEN_W-1:0] count_q, count_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic [31:0] round_in;
    logic [7:0]  round_byte;
    logic [31:0] round_out;

    full_hash_round u_round (
        .state_in  (round_in),
        .byte_in   (round_byte),
        .state_out (round_out)
    );

    always_comb begin
        state_d    = state_q;
        h_d        = h_q;
        count_d    = count_q;
        len_d      = len_q;
        round_in   = h_q;
        round_byte = M;

        case (state_q)
            ST_IDLE: begin
                // The first byte is absorbed straight into IV, not the stale lanes.
                round_in = IV;
                if (M_valid) begin
                    len_d = C_in;
                    if (C_in == '0) begin
                        h_d     = IV;
                        state_d = ST_AFTER_LAST;
                    end else begin
                        h_d     = round_out;
                        count_d = LEN_W'(1);
                        state_d = (C_in == LEN_W'(1)) ? ST_AFTER_LAST : ST_ABSORB;
                    end
                end
            end
            ST_ABSORB: begin
                if (M_valid) begin
                    h_d     = round_out;
                    count_d = count_q + LEN_W'(1);
                    if (count_d == len_q) begin
                        state_d = ST_AFTER_LAST;
                    end
                end
            end
`ifdef LENGTH_FINAL_EN
            ST_FINAL: begin
                round_byte = fold(64'(len_q));
                h_d        = round_out;
                state_d    = ST_DONE;
            end
`endif
            ST_DONE: begin
                if (!M_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            h_q     <= IV;
            count_q <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            count_q <= count_d;
            len_q   <= len_d;
        end
    end

    assign hash_ready = (state_q == ST_DONE);
    assign digest     = (state_q == ST_DONE) ? h_q : 32'h0;

endmodule

// File: tb/tb_full_hash.sv
// Directed bench for full_hash: hand-computed short digests plus a bench-side
// reference model for the longer messages.
module tb_full_hash;

`ifdef LENGTH_FINAL_EN
    localparam int          LAT      = 2;
    localparam logic [31:0] E_LEN0   = 32'h47184D66;
    localparam logic [31:0] E_ONE00  = 32'hCF3596C1;
    localparam logic [31:0] E_ONE01  = 32'h871412E0;
`else
    localparam int          LAT      = 1;
    localparam logic [31:0] E_LEN0   = 32'h34550F14;
    localparam logic [31:0] E_ONE00  = 32'h47184D66;
    localparam logic [31:0] E_ONE01  = 32'h553C05F6;
`endif

    logic        clk;
    logic        rst_n;
    logic        M_valid;
    logic [63:0] C_in;
    logic [7:0]  M;
    logic        hash_ready;
    logic [31:0] digest;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] msg [64];

    full_hash u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .M_valid    (M_valid),
        .C_in       (C_in),
        .M          (M),
        .hash_ready (hash_ready),
        .digest     (digest)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s: got=%08h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] mdl_s4(input logic [3:0] n);
        logic [63:0] tbl;
        int          idx;
        tbl = 64'hC56B90AD3EF84712;
        idx = 63 - 4 * int'(n);
        return tbl[idx -: 4];
    endfunction

    function automatic logic [31:0] mdl_round(input logic [31:0] h, input logic [7:0] b);
        logic [7:0]  lane [4];
        logic [7:0]  k [4];
        logic [7:0]  t;
        logic [7:0]  x;
        logic [31:0] r;
        lane = '{h[31:24], h[23:16], h[15:8], h[7:0]};
        k    = '{8'h3A, 8'hC5, 8'h71, 8'h9E};
        t    = {mdl_s4(b[7:4]), mdl_s4(b[3:0])};
        r    = '0;
        for (int i = 0; i < 4; i++) begin
            x = lane[(i + 1) % 4] ^ t ^ k[i];
            for (int j = 0; j <= i; j++) x = {x[6:0], x[7]};
            r = {r[23:0], x};
        end
        return r;
    endfunction

    function automatic logic [31:0] mdl_digest(input int len);
        logic [31:0] h;
        logic [63:0] l;
        logic [7:0]  f;
        h = 32'h34550F14;
        for (int i = 0; i < len; i++) h = mdl_round(h, msg[i]);
`ifdef LENGTH_FINAL_EN
        l = 64'(len);
        f = '0;
        for (int i = 0; i < 8; i++) f = f ^ l[8*i +: 8];
        h = mdl_round(h, f);
`else
        l = '0;
        f = '0;
`endif
        return h;
    endfunction

    // Sends one message, measures latency from the last accepting edge, checks
    // the digest, optionally holds M_valid in DONE, then returns to IDLE.
    task automatic run_msg(input string tag, input int len, input int gap_max,
                           input bit hold, input logic [31:0] exp);
        int k;
        int g;
        if (len == 0) begin
            M_valid = 1'b1;
            C_in    = 64'd0;
            M       = 8'hEE;
            step();
        end else begin
            for (int i = 0; i < len; i++) begin
                if (i > 0 && gap_max > 0) begin
                    g = $urandom_range(gap_max, 0);
                    repeat (g) begin
                        M_valid = 1'b0;
                        M       = 8'($urandom);
                        step();
                    end
                end
                M_valid = 1'b1;
                C_in    = (i == 0) ? 64'(len) : 64'hDEAD_BEEF_0000_0007;
                M       = msg[i];
                step();
            end
        end
        if (!hold) M_valid = 1'b0;
        k = 1;
        while (!hash_ready && k < 12) begin
            step();
            k++;
        end
        chk({tag, "_lat"}, 32'(k), 32'(LAT));
        chk({tag, "_dig"}, digest, exp);
        if (hold) begin
            repeat (3) step();
            chk({tag, "_hold_rdy"}, 32'(hash_ready), 32'd1);
            chk({tag, "_hold_dig"}, digest, exp);
        end
        M_valid = 1'b0;
        step();
        chk({tag, "_idle_rdy"}, 32'(hash_ready), 32'd0);
        chk({tag, "_idle_dig"}, digest, 32'h0);
    endtask

    initial begin
        rst_n   = 1'b1;
        M_valid = 1'b0;
        C_in    = '0;
        M       = '0;
        step();
        step();
        chk("rst_rdy", 32'(hash_ready), 32'd0);
        chk("rst_dig", digest, 32'h0);
        rst_n = 1'b0;
        step();

        run_msg("len0", 0, 0, 1'b0, E_LEN0);

        msg[0] = 8'h00;
        run_msg("one00", 1, 0, 1'b0, E_ONE00);
        msg[0] = 8'h01;
        run_msg("one01", 1, 0, 1'b0, E_ONE01);

        for (int i = 0; i < 50; i++) msg[i] = 8'(i);
        run_msg("m50", 50, 0, 1'b1, mdl_digest(50));
        run_msg("m50gap", 50, 3, 1'b0, mdl_digest(50));

        // Reset part-way through a message must discard all progress.
        M_valid = 1'b1;
        C_in    = 64'd50;
        for (int i = 0; i < 10; i++) begin
            M = msg[i];
            step();
        end
        rst_n = 1'b1;
        step();
        chk("midrst_rdy", 32'(hash_ready), 32'd0);
        chk("midrst_dig", digest, 32'h0);
        rst_n   = 1'b0;
        M_valid = 1'b0;
        step();
        run_msg("m50after", 50, 0, 1'b1, mdl_digest(50));

        msg[0] = 8'hA5;
        msg[1] = 8'h5A;
        msg[2] = 8'hFF;
        run_msg("b2b3", 3, 0, 1'b1, mdl_digest(3));

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
